// File: rtl/zpower_pkg.sv
// Shared types and sizing helpers for the rail power sequencer.
package zpower_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Timer must count up to the larger of the settle delay and the ramp timeout.
  function automatic int cnt_width(input int dly_cyc, input int pg_timeout);
    int max_v;
    max_v = (dly_cyc > pg_timeout) ? dly_cyc : pg_timeout;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/zpower_pg_filter.sv
// Power-good qualifier: 2-flop synchroniser plus deglitch counter.
// Rises 2+DEGLITCH cycles after a stable high input; falls 3 cycles after the first low.
module zpower_pg_filter #(
  parameter int DEGLITCH = 8
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iPg,
  output logic oPgOk
);

  localparam int DW = $clog2(DEGLITCH + 1);

  logic          sync1_q, sync2_q;
  logic          pg_ok_q, pg_ok_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    pg_ok_d = pg_ok_q;
    if (!sync2_q) begin
      cnt_d   = '0;
      pg_ok_d = 1'b0;
    end else begin
      if (cnt_q != DW'(DEGLITCH)) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= DW'(DEGLITCH - 1)) pg_ok_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      pg_ok_q <= 1'b0;
    end else begin
      sync1_q <= iPg;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      pg_ok_q <= pg_ok_d;
    end
  end

  assign oPgOk = pg_ok_q;

endmodule

// File: rtl/zpower_sequencer.sv
// Ordered rail power-up/down sequencer with power-good supervision and latched fault.
// All outputs registered; one cycle from a qualified input event to the output change.
module zpower_sequencer
  import zpower_pkg::*;
#(
  parameter int NUM_RAILS  = 4,
  parameter int DLY_CYC    = 1000,
  parameter int PG_TIMEOUT = 100000,
  parameter int DEGLITCH   = 8,
  parameter int CNT_W      = cnt_width(DLY_CYC, PG_TIMEOUT)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic [NUM_RAILS-1:0] iPg,
  input  logic                 iClrFault,
  output logic [NUM_RAILS-1:0] oRailEn,
  output logic                 oAllGood,
  output logic                 oFault,
  output logic [IDX_W-1:0]     oFaultRail,
  output logic [2:0]           oState
);

  localparam int MAXR = 1 << IDX_W;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
  logic                   all_good_q, all_good_d;
  logic                   fault_q, fault_d;
  logic [IDX_W-1:0]       fault_rail_q, fault_rail_d;

  logic [NUM_RAILS-1:0]   pg_ok;
  logic [MAXR-1:0]        pg_ok_pad;
  logic                   low_vld;
  logic [IDX_W-1:0]       low_idx;
  logic                   dly_done, pg_timeout;

  for (genvar r = 0; r < NUM_RAILS; r++) begin : g_pg
    zpower_pg_filter #(.DEGLITCH(DEGLITCH)) u_pg_filter (
      .iClk  (iClk),
      .iRst  (iRst),
      .iPg   (iPg[r]),
      .oPgOk (pg_ok[r])
    );
  end

  always_comb begin
    pg_ok_pad                = '0;
    pg_ok_pad[NUM_RAILS-1:0] = pg_ok;
  end

  // Lowest already-enabled rail whose power-good has dropped; the rail being
  // ramped only counts once it has been qualified (SETTLE/ON).
  always_comb begin
    logic incl;
    incl    = (state_q == ST_SETTLE) || (state_q == ST_ON);
    low_vld = 1'b0;
    low_idx = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if (!low_vld && !pg_ok[j] &&
          ((j < int'(idx_q)) || (incl && (j == int'(idx_q))))) begin
        low_vld = 1'b1;
        low_idx = IDX_W'(j);
      end
    end
  end

  assign dly_done   = (timer_q == CNT_W'(DLY_CYC - 1));
  assign pg_timeout = (timer_q == CNT_W'(PG_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;

    case (state_q)
      ST_IDLE: begin
        rail_en_d = '0;
        if (iEn) begin
          idx_d        = '0;
          rail_en_d[0] = 1'b1;
          state_d      = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (low_vld) begin
          state_d      = ST_FAULT;
          fault_rail_d = low_idx;
        end else if (!iEn) begin
          state_d = ST_RAMP_DOWN;
        end else if (pg_ok_pad[idx_q]) begin
          state_d = ST_SETTLE;
        end else if (pg_timeout) begin
          state_d      = ST_FAULT;
          fault_rail_d = idx_q;
        end
      end
      ST_SETTLE: begin
        if (low_vld) begin
          state_d      = ST_FAULT;
          fault_rail_d = low_idx;
        end else if (!iEn) begin
          state_d = ST_RAMP_DOWN;
        end else if (dly_done) begin
          if (idx_q == IDX_W'(NUM_RAILS - 1)) begin
            state_d = ST_ON;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RAMP_UP;
            for (int r = 0; r < NUM_RAILS; r++)
              if (IDX_W'(r) == idx_d) rail_en_d[r] = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (low_vld) begin
          state_d      = ST_FAULT;
          fault_rail_d = low_idx;
        end else if (!iEn) begin
          state_d = ST_RAMP_DOWN;
          idx_d   = IDX_W'(NUM_RAILS - 1);
        end
      end
      ST_RAMP_DOWN: begin
        if (dly_done) begin
          for (int r = 0; r < NUM_RAILS; r++)
            if (IDX_W'(r) == idx_q) rail_en_d[r] = 1'b0;
          if (idx_q == '0) state_d = ST_IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      ST_FAULT: begin
        rail_en_d = '0;
        if (iClrFault && !iEn) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rail_en_d = '0;
      end
    endcase

    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      rail_en_d = '0;
      fault_d   = 1'b1;
    end

    all_good_d = (state_d == ST_ON) && (&pg_ok);
    timer_d    = ((state_d != state_q) || (idx_d != idx_q)) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      rail_en_q    <= '0;
      all_good_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      rail_en_q    <= rail_en_d;
      all_good_q   <= all_good_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  assign oRailEn    = rail_en_q;
  assign oAllGood   = all_good_q;
  assign oFault     = fault_q;
  assign oFaultRail = fault_rail_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_zpower_sequencer.sv
// Directed bench for zpower_sequencer with a simple regulator model (pg follows enable after 5 cycles).
module tb_zpower_sequencer;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iEn = 1'b0;
  logic       iClrFault = 1'b0;
  logic [3:0] iPg;
  logic [3:0] oRailEn;
  logic       oAllGood;
  logic       oFault;
  logic [2:0] oFaultRail;
  logic [2:0] oState;

  logic [3:0] reg_pg    = 4'b0000;
  logic [3:0] pg_block  = 4'b0000;
  logic [3:0] pg_kill   = 4'b0000;
  logic [3:0] pg_glitch = 4'b0000;
  int         en_cnt[4] = '{0, 0, 0, 0};

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  assign iPg = (reg_pg & ~pg_block & ~pg_kill) | pg_glitch;

  zpower_sequencer #(
    .NUM_RAILS (4),
    .DLY_CYC   (10),
    .PG_TIMEOUT(50),
    .DEGLITCH  (4),
    .CNT_W     (17)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iPg       (iPg),
    .iClrFault (iClrFault),
    .oRailEn   (oRailEn),
    .oAllGood  (oAllGood),
    .oFault    (oFault),
    .oFaultRail(oFaultRail),
    .oState    (oState)
  );

  always #5 iClk = ~iClk;

  // Regulator model: power-good goes high in the 5th cycle a rail is enabled, drops with the enable.
  always @(posedge iClk) begin
    #1;
    for (int r = 0; r < 4; r++) begin
      if (oRailEn[r]) begin
        if (en_cnt[r] < 100) en_cnt[r]++;
      end else begin
        en_cnt[r] = 0;
      end
      reg_pg[r] = (en_cnt[r] >= 5);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0:       probe = 32'(oRailEn);
      1:       probe = 32'(oState);
      default: probe = 32'(oFault);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic [31:0] exp,
                          input int budget, output int cycles);
    cycles = 0;
    while (probe(sel) !== exp && cycles < budget) begin
      tick(1);
      cycles++;
    end
    if (probe(sel) !== exp) check({tag, "_timeout"}, probe(sel), exp);
  endtask

  task automatic clear_fault();
    iEn       = 1'b0;
    iClrFault = 1'b1;
    tick(1);
    iClrFault = 1'b0;
    tick(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: reset state, then reset asserted mid-ramp
    tick(2);
    check("rst_outputs", {oRailEn, oAllGood, oFault, oFaultRail, oState}, 0);
    iRst = 1'b0;
    tick(1);
    check("idle_state", oState, 0);
    iEn = 1'b1;
    wait_for("rst_ramp", 0, 4'b0111, 80, cyc);
    check("rst_ramp_state", oState, 1);
    #3 iRst = 1'b1;
    #1 check("rst_async", {oRailEn, oAllGood, oFault, oFaultRail, oState}, 0);
    iEn = 1'b0;
    tick(2);
    iRst = 1'b0;
    tick(1);
    check("rst_release", {oRailEn, oAllGood, oFault, oFaultRail, oState}, 0);
    tick(8);

    // 2: nominal power-up
    iEn = 1'b1;
    tick(1);
    check("up_r0", oRailEn, 4'b0001);
    check("up_r0_state", oState, 1);
    wait_for("up_r1", 0, 4'b0011, 40, cyc);
    check("up_gap01", cyc, 21);
    wait_for("up_r2", 0, 4'b0111, 40, cyc);
    check("up_gap12", cyc, 21);
    wait_for("up_r3", 0, 4'b1111, 40, cyc);
    check("up_gap23", cyc, 21);
    wait_for("up_on", 1, 3, 40, cyc);
    check("up_gap3on", cyc, 21);
    check("up_allgood", oAllGood, 1);

    // 3: ordered power-down
    iEn = 1'b0;
    tick(1);
    check("dn_state", oState, 4);
    check("dn_allgood", oAllGood, 0);
    check("dn_rails", oRailEn, 4'b1111);
    wait_for("dn_r3", 0, 4'b0111, 20, cyc);
    check("dn_gap3", cyc, 10);
    wait_for("dn_r2", 0, 4'b0011, 20, cyc);
    check("dn_gap2", cyc, 10);
    wait_for("dn_r1", 0, 4'b0001, 20, cyc);
    check("dn_gap1", cyc, 10);
    wait_for("dn_r0", 0, 4'b0000, 20, cyc);
    check("dn_gap0", cyc, 10);
    check("dn_idle", oState, 0);
    tick(8);

    // 4: ramp timeout on rail 1
    pg_block = 4'b0010;
    iEn      = 1'b1;
    wait_for("to_r1", 0, 4'b0011, 40, cyc);
    wait_for("to_fault", 2, 1, 80, cyc);
    check("to_latency", cyc, 50);
    check("to_rail", oFaultRail, 1);
    check("to_rails_off", oRailEn, 0);
    check("to_state", oState, 5);
    iClrFault = 1'b1;
    tick(1);
    iClrFault = 1'b0;
    tick(1);
    check("to_clr_ignored", {oFault, oState}, {1'b1, 3'd5});
    iEn       = 1'b0;
    iClrFault = 1'b1;
    tick(1);
    iClrFault = 1'b0;
    check("to_clr", {oFault, oState}, {1'b0, 3'd0});
    pg_block = 4'b0000;
    tick(8);

    // 5: short pg pulse must not qualify; 1-cycle brown-out in ON faults
    pg_block = 4'b0100;
    iEn      = 1'b1;
    wait_for("gl_r2", 0, 4'b0111, 80, cyc);
    tick(3);
    pg_glitch = 4'b0100;
    tick(2);
    pg_glitch = 4'b0000;
    tick(30);
    check("gl_no_adv", {oRailEn, oState}, {4'b0111, 3'd1});
    check("gl_no_fault", oFault, 0);
    pg_block = 4'b0000;
    wait_for("gl_on", 1, 3, 60, cyc);
    check("gl_allgood", oAllGood, 1);
    pg_kill = 4'b0001;
    tick(1);
    pg_kill = 4'b0000;
    wait_for("bo_fault", 2, 1, 10, cyc);
    check("bo_latency", cyc, 3);
    check("bo_rail", oFaultRail, 0);
    check("bo_rails_off", oRailEn, 0);
    clear_fault();

    // 6a: two rails drop together, lowest index reported
    iEn = 1'b1;
    wait_for("sim_on", 1, 3, 120, cyc);
    pg_kill = 4'b1010;
    tick(3);
    pg_kill = 4'b0000;
    wait_for("sim_fault", 2, 1, 10, cyc);
    check("sim_rail", oFaultRail, 1);
    clear_fault();

    // 6b: enable dropped while rail 1 settles -> partial ramp-down
    iEn = 1'b1;
    wait_for("pd_r1", 0, 4'b0011, 40, cyc);
    wait_for("pd_settle", 1, 2, 20, cyc);
    iEn = 1'b0;
    tick(1);
    check("pd_state", {oRailEn, oState}, {4'b0011, 3'd4});
    wait_for("pd_r1off", 0, 4'b0001, 20, cyc);
    check("pd_gap1", cyc, 10);
    wait_for("pd_r0off", 0, 4'b0000, 20, cyc);
    check("pd_gap0", cyc, 10);
    check("pd_idle", oState, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
